// File: rtl/vgaminikbd_pkg.sv
// Shared constants and helpers for the keyboard/terminal byte path.
package vgaminikbd_pkg;

  localparam logic ARB_MODE_FIXED = 1'b0;
  localparam logic ARB_MODE_RR    = 1'b1;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous FIFO with wrap-bit pointers and combinational head output.
module byte_fifo
  import vgaminikbd_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int unsigned AW = clog2(DEPTH);

  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic [DW-1:0] mem [DEPTH];
  logic          wr_en;
  logic          rd_en;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rd_en = pop && !empty;
  // A full FIFO still takes a write when its head leaves in the same cycle.
  assign wr_en = push && (!full || rd_en);
  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + (AW+1)'(1);
      if (rd_en) rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/arb_nx1.sv
// N-channel buffered byte arbiter: fixed-priority or round-robin merge into
// one registered valid/ready stream, with sticky per-channel overflow flags.
module arb_nx1
  import vgaminikbd_pkg::*;
#(
  parameter int unsigned NCH   = 4,
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode,
  input  logic [NCH*DW-1:0] din,
  input  logic [NCH-1:0]    dinv,
  output logic [DW-1:0]     od,
  output logic              odv,
  input  logic              ordy,
  output logic [NCH-1:0]    ovf,
  input  logic              ovf_clr,
  output logic [NCH-1:0]    fempty
);

  localparam int unsigned CW = clog2(NCH);

  logic [NCH-1:0]         full;
  logic [NCH-1:0]         empty;
  logic [NCH-1:0]         pop;
  logic [NCH-1:0]         ovf_set;
  logic [NCH-1:0][DW-1:0] head;
  logic                   load;
  logic                   gnt_valid;
  logic [CW-1:0]          gidx;
  logic [CW-1:0]          rr_ptr;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    byte_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (dinv[i]),
      .pop   (pop[i]),
      .wdata (din[i*DW +: DW]),
      .rdata (head[i]),
      .full  (full[i]),
      .empty (empty[i])
    );
  end

  assign fempty = empty;
  assign load   = !odv || ordy;

  // Grant search: highest non-empty index, or first non-empty after rr_ptr.
  always_comb begin
    int unsigned j;
    gnt_valid = 1'b0;
    gidx      = '0;
    j         = 0;
    if (mode == ARB_MODE_FIXED) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (!empty[i]) begin
          gnt_valid = 1'b1;
          gidx      = CW'(i);
        end
      end
    end else begin
      for (int unsigned k = 1; k <= NCH; k++) begin
        j = 32'(rr_ptr) + k;
        if (j >= NCH) j = j - NCH;
        if (!gnt_valid && !empty[CW'(j)]) begin
          gnt_valid = 1'b1;
          gidx      = CW'(j);
        end
      end
    end
  end

  always_comb begin
    pop     = '0;
    ovf_set = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      pop[i]     = load && gnt_valid && (gidx == CW'(i));
      ovf_set[i] = dinv[i] && full[i] && !pop[i];
    end
  end

  // Output register; rr_ptr follows every grant regardless of mode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      od     <= '0;
      odv    <= 1'b0;
      rr_ptr <= CW'(NCH - 1);
      ovf    <= '0;
    end else begin
      if (load) begin
        if (gnt_valid) begin
          od     <= head[gidx];
          odv    <= 1'b1;
          rr_ptr <= gidx;
        end else begin
          odv <= 1'b0;
        end
      end
      ovf <= (ovf & ~{NCH{ovf_clr}}) | ovf_set;
    end
  end

endmodule

// File: tb/tb_arb_nx1.sv
// Directed bench for arb_nx1 with NCH=4, DW=8, DEPTH=4.
module tb_arb_nx1;

  logic        clk;
  logic        reset;
  logic        mode;
  logic [31:0] din;
  logic [3:0]  dinv;
  logic [7:0]  od;
  logic        odv;
  logic        ordy;
  logic [3:0]  ovf;
  logic        ovf_clr;
  logic [3:0]  fempty;

  int checks = 0;
  int errors = 0;

  arb_nx1 #(.NCH(4), .DW(8), .DEPTH(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .mode    (mode),
    .din     (din),
    .dinv    (dinv),
    .od      (od),
    .odv     (odv),
    .ordy    (ordy),
    .ovf     (ovf),
    .ovf_clr (ovf_clr),
    .fempty  (fempty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int ch, input logic [7:0] b);
    din[ch*8 +: 8] = b;
    dinv[ch]       = 1'b1;
  endtask

  task automatic do_reset();
    dinv    = '0;
    din     = '0;
    ordy    = 1'b0;
    ovf_clr = 1'b0;
    reset   = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    mode = 1'b0;
    do_reset();
    if (odv !== 1'b0) begin errors++; $display("FAIL rst_odv got=%b exp=0", odv); end
    checks++;
    if (od !== 8'h00) begin errors++; $display("FAIL rst_od got=%h exp=00", od); end
    checks++;
    if (ovf !== 4'b0000) begin errors++; $display("FAIL rst_ovf got=%b exp=0000", ovf); end
    checks++;
    if (fempty !== 4'b1111) begin errors++; $display("FAIL rst_fempty got=%b exp=1111", fempty); end
    checks++;
    // traffic then asynchronous reset mid-flight
    put(2, 8'h77);
    tick();
    dinv = '0;
    tick();
    if (od !== 8'h77 || odv !== 1'b1) begin errors++; $display("FAIL pre_rst od=%h odv=%b exp=77/1", od, odv); end
    checks++;
    put(1, 8'h12);
    tick();
    dinv = '0;
    #1 reset = 1'b1;
    #1;
    if (odv !== 1'b0 || od !== 8'h00) begin errors++; $display("FAIL async_rst od=%h odv=%b exp=00/0", od, odv); end
    checks++;
    if (fempty !== 4'b1111) begin errors++; $display("FAIL async_rst_fempty got=%b exp=1111", fempty); end
    checks++;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (odv !== 1'b0 || od !== 8'h00 || fempty !== 4'b1111 || ovf !== 4'b0000) begin
        errors++;
        $display("FAIL post_rst_idle od=%h odv=%b fempty=%b ovf=%b exp=00/0/1111/0000", od, odv, fempty, ovf);
      end
      checks++;
    end
  endtask

  task automatic test_fixed_priority();
    mode = 1'b0;
    do_reset();
    ordy = 1'b1;
    put(0, 8'h11);
    put(3, 8'h33);
    tick();
    dinv = '0;
    tick();
    if (od !== 8'h33 || odv !== 1'b1) begin errors++; $display("FAIL fp_first od=%h odv=%b exp=33/1", od, odv); end
    checks++;
    tick();
    if (od !== 8'h11 || odv !== 1'b1) begin errors++; $display("FAIL fp_second od=%h odv=%b exp=11/1", od, odv); end
    checks++;
    tick();
    if (odv !== 1'b0 || od !== 8'h11) begin errors++; $display("FAIL fp_idle od=%h odv=%b exp=11/0", od, odv); end
    checks++;
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_seq [8];
    exp_seq = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h01, 8'h11, 8'h21, 8'h31};
    mode = 1'b1;
    do_reset();
    ordy = 1'b1;
    din  = {8'h30, 8'h20, 8'h10, 8'h00};
    dinv = 4'b1111;
    tick();
    din = {8'h31, 8'h21, 8'h11, 8'h01};
    tick();
    dinv = '0;
    for (int k = 0; k < 8; k++) begin
      if (od !== exp_seq[k] || odv !== 1'b1) begin
        errors++;
        $display("FAIL rr_seq[%0d] od=%h odv=%b exp=%h/1", k, od, odv, exp_seq[k]);
      end
      checks++;
      tick();
    end
    if (odv !== 1'b0) begin errors++; $display("FAIL rr_idle odv=%b exp=0", odv); end
    checks++;
  endtask

  task automatic test_backpressure();
    mode = 1'b0;
    do_reset();
    put(0, 8'h55);
    tick();
    put(0, 8'h66);
    tick();
    dinv = '0;
    for (int k = 0; k < 10; k++) begin
      if (od !== 8'h55 || odv !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold[%0d] od=%h odv=%b exp=55/1", k, od, odv);
      end
      checks++;
      tick();
    end
    ordy = 1'b1;
    tick();
    if (od !== 8'h66 || odv !== 1'b1) begin errors++; $display("FAIL bp_next od=%h odv=%b exp=66/1", od, odv); end
    checks++;
    tick();
    if (odv !== 1'b0) begin errors++; $display("FAIL bp_idle odv=%b exp=0", odv); end
    checks++;
  endtask

  task automatic test_overflow();
    mode = 1'b0;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      put(1, 8'(8'hA0 + k));
      tick();
    end
    dinv = '0;
    if (ovf !== 4'b0010) begin errors++; $display("FAIL ovf_set got=%b exp=0010", ovf); end
    checks++;
    if (od !== 8'hA0 || odv !== 1'b1) begin errors++; $display("FAIL ovf_head od=%h odv=%b exp=A0/1", od, odv); end
    checks++;
    if (fempty !== 4'b1101) begin errors++; $display("FAIL ovf_fempty got=%b exp=1101", fempty); end
    checks++;
    ordy = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (od !== 8'(8'hA0 + k) || odv !== 1'b1) begin
        errors++;
        $display("FAIL ovf_drain[%0d] od=%h odv=%b exp=%h/1", k, od, odv, 8'(8'hA0 + k));
      end
      checks++;
    end
    tick();
    if (odv !== 1'b0 || ovf !== 4'b0010) begin errors++; $display("FAIL ovf_after odv=%b ovf=%b exp=0/0010", odv, ovf); end
    checks++;
    // refill to full, then clear and overflow in the same cycle
    ordy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      put(1, 8'(8'hB0 + k));
      tick();
    end
    put(1, 8'hB5);
    ovf_clr = 1'b1;
    tick();
    dinv = '0;
    if (ovf !== 4'b0010) begin errors++; $display("FAIL ovf_clr_race got=%b exp=0010", ovf); end
    checks++;
    tick();
    ovf_clr = 1'b0;
    if (ovf !== 4'b0000) begin errors++; $display("FAIL ovf_clr got=%b exp=0000", ovf); end
    checks++;
    ordy = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (od !== 8'(8'hB0 + k)) begin
        errors++;
        $display("FAIL ovf_drain2[%0d] od=%h exp=%h", k, od, 8'(8'hB0 + k));
      end
      checks++;
    end
    tick();
    if (odv !== 1'b0) begin errors++; $display("FAIL ovf_idle2 odv=%b exp=0", odv); end
    checks++;
  endtask

  task automatic test_full_plus_pop();
    mode = 1'b0;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      put(2, 8'(8'hC0 + k));
      tick();
    end
    if (od !== 8'hC0 || fempty !== 4'b1011 || ovf !== 4'b0000) begin
      errors++;
      $display("FAIL fpp_pre od=%h fempty=%b ovf=%b exp=C0/1011/0000", od, fempty, ovf);
    end
    checks++;
    ordy = 1'b1;
    put(2, 8'hC5);
    tick();
    if (od !== 8'hC1 || ovf !== 4'b0000) begin
      errors++;
      $display("FAIL fpp_accept od=%h ovf=%b exp=C1/0000", od, ovf);
    end
    checks++;
    // a further stalled push must overflow if the FIFO stayed full
    ordy = 1'b0;
    put(2, 8'hC6);
    tick();
    dinv = '0;
    if (ovf !== 4'b0100 || od !== 8'hC1) begin
      errors++;
      $display("FAIL fpp_still_full ovf=%b od=%h exp=0100/C1", ovf, od);
    end
    checks++;
    ordy = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      tick();
      if (od !== 8'(8'hC0 + k) || odv !== 1'b1) begin
        errors++;
        $display("FAIL fpp_drain[%0d] od=%h odv=%b exp=%h/1", k, od, odv, 8'(8'hC0 + k));
      end
      checks++;
    end
    tick();
    if (odv !== 1'b0) begin errors++; $display("FAIL fpp_idle odv=%b exp=0", odv); end
    checks++;
  endtask

  initial begin
    reset   = 1'b1;
    mode    = 1'b0;
    din     = '0;
    dinv    = '0;
    ordy    = 1'b0;
    ovf_clr = 1'b0;
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_backpressure();
    test_overflow();
    test_full_plus_pop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arb_nx1.md
Name: arb_nx1

Overview:
- N-channel byte arbiter merging independent byte sources (PS/2 keyboard decoder, UART RX, host port) into one byte stream for the VGA terminal character path.
- Successor to the fixed 2-input combinational merger: parametrised channel count and data width, per-channel input buffering, selectable fixed-priority or round-robin arbitration, registered output with valid/ready backpressure, and sticky overflow flags.

Parameters:
- NCH, 4, number of input channels (2..8).
- DW, 8, data width per channel.
- DEPTH, 4, per-channel FIFO depth in entries (power of 2, at least 2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- mode  input  1  0 = fixed priority, highest index wins; 1 = round-robin.
- din  input  NCH*DW  channel i data at bits [i*DW +: DW].
- dinv  input  NCH  channel i write strobe, one byte per cycle while high; no backpressure to sources.
- od  output  DW  output byte, registered.
- odv  output  1  od valid, registered.
- ordy  input  1  consumer accepts od when odv && ordy.
- ovf  output  NCH  sticky per-channel overflow flag.
- ovf_clr  input  1  clears all ovf bits.
- fempty  output  NCH  per-channel FIFO empty status, registered state.

Behaviour:
- Reset, asynchronous: all FIFOs empty; od = 0, odv = 0, ovf = 0, fempty = all ones, round-robin pointer = NCH-1.
- Push rule: dinv[i] writes din[i] into FIFO i when FIFO i is not full. FIFO i may also accept a write while full if it is popped in the same cycle.
- Overflow: if FIFO i is full and not popped in that cycle, the write is dropped and ovf[i] is set. If ovf_clr and a new overflow occur in the same cycle, the set wins.
- Load condition: load = !odv || ordy.
- Grant: on a load cycle, if any FIFO is non-empty, exactly one channel g is granted. FIFO g is popped, od takes its head entry and odv goes to 1 on the next edge.
- No grant: on a load cycle with all FIFOs empty, odv goes to 0 and od holds its last value.
- Stall: while odv && !ordy, od and odv hold and no FIFO is popped.
- Fixed priority (mode = 0): g is the highest index among non-empty FIFOs. This matches the legacy rule that the higher channel wins.
- Round-robin (mode = 1):
  - Search starts at pointer+1 and wraps modulo NCH; g is the first non-empty FIFO found.
  - The pointer updates to g only on a grant.
  - In mode 0 the pointer still tracks the last grant, so switching modes takes effect cleanly at the next load.
- Latency: a byte pushed at edge t is visible in the FIFO after t and appears on od/odv after edge t+1, assuming the output is idle and the channel wins.
- Throughput: with ordy held high, one byte per cycle.
- Per-channel ordering is preserved. There is no ordering guarantee across channels.
- FIFO wrap-around: read/write pointers are log2(DEPTH) bits plus one extra wrap bit. Full = equal index with differing wrap bit; empty = equal pointers.
- Reset mid-operation: all buffered and in-flight bytes are discarded; the block is idle in the cycle after reset deasserts.
- Unused din bits of a channel whose dinv is low are ignored.

Decomposition:
- Shared package vgaminikbd_pkg holds:
  - ARB_MODE_FIXED = 1'b0 and ARB_MODE_RR = 1'b1;
  - a clog2 helper function.
- One sub-module, byte_fifo (parametrised DW, DEPTH):
  - ports: push, pop, wdata, rdata (head entry, combinational), full, empty;
  - NCH instances via a generate loop.
- Arbitration search, output register and ovf logic live in arb_nx1.

Test Plan:
- Reset and idle: assert reset mid-traffic -> next cycle odv = 0, od = 0x00, ovf = 0, fempty = 4'b1111; no output until a new push.
- Fixed priority, ordy = 1: push 0x11 on ch0 and 0x33 on ch3 in the same cycle -> od sequence 0x33 then 0x11 on consecutive cycles, then odv = 0.
- Round-robin fairness:
  - mode = 1, ordy = 1, channels 0..3 each preloaded with 2 bytes (ch i holds 0xi0 then 0xi1);
  - required od sequence: 0x00, 0x10, 0x20, 0x30, 0x01, 0x11, 0x21, 0x31.
- Backpressure:
  - ordy = 0 with 0x55 held on od -> od/odv stable for 10 cycles;
  - raise ordy -> 0x55 accepted once, and the next byte follows on the next cycle.
- Overflow:
  - ordy = 0, push 6 bytes 0xA0..0xA5 into ch1 (DEPTH = 4); 0xA0 is loaded to od and 4 bytes are buffered, so ovf[1] = 1;
  - release ordy -> exactly 0xA0..0xA4 emerge;
  - assert ovf_clr in the same cycle as a new overflow -> ovf[1] stays 1.
- Full-plus-pop: ch2 full, ordy = 1, ch2 granted while dinv[2] = 1 -> write accepted, ovf[2] stays 0, FIFO stays full.
